// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line endpoint: receives 48-bit command tokens, checks
// framing and CRC7, hands index/argument to card logic, then serialises the
// short (48-bit) or long (136-bit) response back onto the line.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | line released, waiting for a start bit
// S_RX       | shifting in command bits 46..0, CRC check on bit 0
// S_WAIT_RSP | command accepted, waiting up to NCR_MAX cycles for rsp_valid
// S_GAP      | driving the line high until the minimum Ncr gap has elapsed
// S_TX       | shifting the response out MSB first, CRC7 appended
// S_HOLD     | one cycle driving high after the end bit, release next
module sd_card_cmd_responder #(
  parameter int NCR_MIN = 2,
  parameter int NCR_MAX = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cmd_pin_in,
  output logic         cmd_pin_out,
  output logic         cmd_oe,
  output logic         cmd_valid,
  output logic [5:0]   cmd_index,
  output logic [31:0]  cmd_arg,
  output logic         cmd_crc_err,
  input  logic         rsp_valid,
  input  logic [1:0]   rsp_kind,
  input  logic [5:0]   rsp_index,
  input  logic [31:0]  rsp_status,
  input  logic [119:0] rsp_long,
  output logic         rsp_ack,
  output logic         busy
);

  // The Ncr timer counts down from NCR_MAX-1 on the cycle after the command
  // end bit, so a value of NCR_MAX-k means k cycles have elapsed. It
  // saturates at zero, which keeps the gap compare valid for late responses.
  localparam int TW = $clog2(NCR_MAX + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(NCR_MAX - 1);
  localparam logic [TW-1:0] GAP_DONE = TW'(NCR_MAX - NCR_MIN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_WAIT_RSP,
    S_GAP,
    S_TX,
    S_HOLD
  } state_t;

  state_t         state;
  logic [5:0]     rx_cnt;
  logic [44:0]    rx_sr;
  logic [6:0]     crc;
  logic [TW-1:0]  tmr;
  logic [126:0]   tx_sr;
  logic [7:0]     tx_cnt;
  logic           tx_long;

  // One CRC7 step (x^7 + x^3 + 1), data MSB first.
  function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  // Whole controller: receive, check, wait, gap, transmit, hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      rx_cnt      <= '0;
      rx_sr       <= '0;
      crc         <= '0;
      tmr         <= '0;
      tx_sr       <= '0;
      tx_cnt      <= '0;
      tx_long     <= 1'b0;
      cmd_pin_out <= 1'b1;
      cmd_oe      <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_crc_err <= 1'b0;
      cmd_index   <= '0;
      cmd_arg     <= '0;
      rsp_ack     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      cmd_valid   <= 1'b0;
      cmd_crc_err <= 1'b0;
      rsp_ack     <= 1'b0;
      case (state)
        S_IDLE: begin
          // Start bit is a zero and leaves the zero-initialised CRC unchanged.
          if (!cmd_pin_in) begin
            state  <= S_RX;
            rx_cnt <= 6'd46;
            crc    <= '0;
            busy   <= 1'b1;
          end
        end

        S_RX: begin
          rx_cnt <= rx_cnt - 6'd1;
          if (rx_cnt == 6'd46) begin
            // Transmission bit 0 means another card's response: drop silently.
            if (!cmd_pin_in) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              crc <= crc7_next(crc, 1'b1);
            end
          end else if (rx_cnt != 6'd0) begin
            rx_sr <= {rx_sr[43:0], cmd_pin_in};
            if (rx_cnt >= 6'd8) begin
              crc <= crc7_next(crc, cmd_pin_in);
            end
          end else begin
            if (cmd_pin_in && (rx_sr[6:0] == crc)) begin
              cmd_index <= rx_sr[44:39];
              cmd_arg   <= rx_sr[38:7];
              cmd_valid <= 1'b1;
              tmr       <= TMR_LOAD;
              state     <= S_WAIT_RSP;
            end else begin
              cmd_crc_err <= 1'b1;
              state       <= S_IDLE;
              busy        <= 1'b0;
            end
          end
        end

        S_WAIT_RSP: begin
          if (tmr != '0) tmr <= tmr - 1'b1;
          if (rsp_valid) begin
            rsp_ack <= 1'b1;
            case (rsp_kind)
              2'b01: begin
                tx_sr       <= {1'b0, rsp_index, rsp_status, 88'd0};
                tx_cnt      <= 8'd47;
                tx_long     <= 1'b0;
                cmd_oe      <= 1'b1;
                cmd_pin_out <= 1'b1;
                state       <= S_GAP;
              end
              2'b10: begin
                tx_sr       <= {1'b0, 6'h3f, rsp_long};
                tx_cnt      <= 8'd135;
                tx_long     <= 1'b1;
                cmd_oe      <= 1'b1;
                cmd_pin_out <= 1'b1;
                state       <= S_GAP;
              end
              default: begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            endcase
          end else if (tmr == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        S_GAP: begin
          if (tmr != '0) tmr <= tmr - 1'b1;
          // Leaving the gap drives the start bit; the CRC of a leading zero is zero.
          if (tmr < GAP_DONE) begin
            cmd_pin_out <= 1'b0;
            crc         <= '0;
            state       <= S_TX;
          end
        end

        S_TX: begin
          // tx_cnt = bits still to send after the start bit; 0 is the hold cycle.
          if (tx_cnt > 8'd8) begin
            cmd_pin_out <= tx_sr[126];
            tx_sr       <= {tx_sr[125:0], 1'b0};
            // Long responses exclude the 0/111111 header from the CRC.
            if (!tx_long || (tx_cnt <= 8'd128)) begin
              crc <= crc7_next(crc, tx_sr[126]);
            end
            tx_cnt <= tx_cnt - 8'd1;
          end else if (tx_cnt > 8'd1) begin
            cmd_pin_out <= crc[6];
            crc         <= {crc[5:0], 1'b0};
            tx_cnt      <= tx_cnt - 8'd1;
          end else if (tx_cnt == 8'd1) begin
            cmd_pin_out <= 1'b1;
            tx_cnt      <= 8'd0;
          end else begin
            cmd_pin_out <= 1'b1;
            state       <= S_HOLD;
          end
        end

        S_HOLD: begin
          cmd_oe      <= 1'b0;
          cmd_pin_out <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
